// File: rtl/cordic_hyp_gain_comp.sv
// Gain compensation for a hyperbolic CORDIC vectoring result: serial shift-add
// multiply of X by 1/K_h with rounding and saturation. Optional macro CORDIC_HYP_LN_MODE_EN doubles Z (ln mode).
module cordic_hyp_gain_comp #(
   parameter logic [15:0] GAIN_INV = 16'h26A4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [15:0] in_x,
   input  logic [15:0] in_z,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [15:0] out_mag,
   output logic [15:0] out_ang,
   output logic        out_sat
);

   typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

   state_t             state, state_nx;
   logic [15:0]        x_q, z_q;
   logic signed [31:0] acc_q, acc_nx, addend;
   logic [3:0]         bit_q;
   logic signed [32:0] rnd, rnd_sh;
   logic [15:0]        mag_nx, ang_nx;
   logic               mag_sat, ang_sat;
   logic               accept;

   assign in_ready = (state == IDLE) && !rst;
   assign accept   = in_valid && in_ready;

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (accept) state_nx = MUL;
         MUL:     if (bit_q == 4'd15) state_nx = DONE;
         DONE:    if (out_ready) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // One multiplier bit per cycle, LSB first; results are formed from acc_nx
   // so the final partial product lands in the same edge that enters DONE.
   always_comb begin
      addend = '0;
      if (GAIN_INV[bit_q]) addend = $signed({{16{x_q[15]}}, x_q}) <<< bit_q;
      acc_nx = acc_q + addend;
      rnd    = {acc_nx[31], acc_nx} + 33'sd4096;
      rnd_sh = rnd >>> 13;
      mag_nx  = rnd_sh[15:0];
      mag_sat = 1'b0;
      if (rnd_sh > 33'sd32767) begin
         mag_nx  = 16'h7FFF;
         mag_sat = 1'b1;
      end else if (rnd_sh < -33'sd32768) begin
         mag_nx  = 16'h8000;
         mag_sat = 1'b1;
      end
   end

`ifdef CORDIC_HYP_LN_MODE_EN
   logic [16:0] z_dbl;
   always_comb begin
      z_dbl   = {z_q, 1'b0};
      ang_nx  = z_dbl[15:0];
      ang_sat = 1'b0;
      if (z_dbl[16] != z_dbl[15]) begin
         ang_nx  = z_dbl[16] ? 16'h8000 : 16'h7FFF;
         ang_sat = 1'b1;
      end
   end
`else
   always_comb begin
      ang_nx  = z_q;
      ang_sat = 1'b0;
   end
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         x_q       <= '0;
         z_q       <= '0;
         acc_q     <= '0;
         bit_q     <= '0;
         out_valid <= 1'b0;
         out_mag   <= '0;
         out_ang   <= '0;
         out_sat   <= 1'b0;
      end else begin
         case (state)
            IDLE: if (accept) begin
               x_q   <= in_x;
               z_q   <= in_z;
               acc_q <= '0;
               bit_q <= '0;
            end
            MUL: begin
               acc_q <= acc_nx;
               bit_q <= bit_q + 4'd1;
               if (bit_q == 4'd15) begin
                  out_mag   <= mag_nx;
                  out_ang   <= ang_nx;
                  out_sat   <= mag_sat | ang_sat;
                  out_valid <= 1'b1;
               end
            end
            DONE: if (out_ready) out_valid <= 1'b0;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_cordic_hyp_gain_comp.sv
// Bench for cordic_hyp_gain_comp: directed vector table, random vectors against
// an arithmetic model, plus backpressure and mid-operation reset sequences.
module tb_cordic_hyp_gain_comp;

   localparam longint GAIN = 64'h26A4;

   logic        clk, rst, in_valid, in_ready, out_valid, out_ready, out_sat;
   logic [15:0] in_x, in_z, out_mag, out_ang;

   int n_vec = 0;
   int n_err = 0;

   cordic_hyp_gain_comp #(.GAIN_INV(16'h26A4)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_x(in_x), .in_z(in_z), .out_valid(out_valid), .out_ready(out_ready),
      .out_mag(out_mag), .out_ang(out_ang), .out_sat(out_sat)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] x;
      logic [15:0] z;
      logic [15:0] mag;
      logic [15:0] ang;
      logic        sat;
      int          hold;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Returns {sat, mag, ang} from plain integer arithmetic.
   function automatic logic [32:0] model(input logic [15:0] x, input logic [15:0] z);
      longint p, r, a;
      logic   s;
      logic [15:0] m, g;
      s = 1'b0;
      p = longint'($signed(x)) * GAIN;
      r = (p + 4096) >>> 13;
      if (r > 32767)       begin m = 16'h7FFF; s = 1'b1; end
      else if (r < -32768) begin m = 16'h8000; s = 1'b1; end
      else                 m = r[15:0];
`ifdef CORDIC_HYP_LN_MODE_EN
      a = 2 * longint'($signed(z));
      if (a > 32767)       begin g = 16'h7FFF; s = 1'b1; end
      else if (a < -32768) begin g = 16'h8000; s = 1'b1; end
      else                 g = a[15:0];
`else
      a = longint'($signed(z));
      g = a[15:0];
`endif
      return {s, m, g};
   endfunction

   // Accept one result, drive junk while busy, check latency and hold behaviour.
   task automatic run_txn(input logic [15:0] x, input logic [15:0] z, input int hold,
                          output logic [15:0] mag, output logic [15:0] ang, output logic sat);
      int lat;
      in_valid = 1'b1; in_x = x; in_z = z; out_ready = 1'b0;
      #1;
      check("in_ready_before_accept", {31'd0, in_ready}, 32'd1);
      @(posedge clk); #1;
      lat = 0;
      for (int i = 1; i <= 40 && lat == 0; i++) begin
         in_valid = 1'($urandom_range(0, 1));
         in_x = 16'($urandom); in_z = 16'($urandom);
         @(posedge clk); #1;
         if (out_valid) lat = i;
      end
      check("latency", lat, 16);
      mag = out_mag; ang = out_ang; sat = out_sat;
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         check("hold_data", {out_mag, out_ang}, {mag, ang});
         check("hold_flags", {29'd0, out_valid, out_sat, in_ready}, {29'd0, 1'b1, sat, 1'b0});
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check("release", {30'd0, out_valid, in_ready}, {30'd0, 1'b0, 1'b1});
   endtask

   vec_t vecs[$];
   vec_t v;
   logic [32:0] e;
   logic [15:0] am, aa;
   logic        as;
   int          seen;

   initial begin
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_x = '0; in_z = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_in_ready", {31'd0, in_ready}, 32'd0);
      check("rst_outputs", {out_mag, out_ang}, 32'd0);
      check("rst_flags", {30'd0, out_valid, out_sat}, 32'd0);
      rst = 1'b0;
      #1;
      check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

      // Directed entries with hand-derived expectations.
`ifdef CORDIC_HYP_LN_MODE_EN
      vecs.push_back('{16'h2000, 16'h1193, 16'h26A4, 16'h2326, 1'b0, 0});
      vecs.push_back('{16'h1000, 16'h5000, 16'h1352, 16'h7FFF, 1'b1, 1});
`else
      vecs.push_back('{16'h2000, 16'h1193, 16'h26A4, 16'h1193, 1'b0, 0});
      vecs.push_back('{16'h1000, 16'h5000, 16'h1352, 16'h5000, 1'b0, 1});
`endif
      vecs.push_back('{16'hE000, 16'h0000, 16'hD95C, 16'h0000, 1'b0, 2});
      vecs.push_back('{16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0, 0});
      vecs.push_back('{16'h7FFF, 16'h0000, 16'h7FFF, 16'h0000, 1'b1, 1});
      for (int i = 0; i < 30; i++) begin
         v.x = 16'($urandom); v.z = 16'($urandom);
         e = model(v.x, v.z);
         v.sat = e[32]; v.mag = e[31:16]; v.ang = e[15:0];
         v.hold = $urandom_range(0, 3);
         vecs.push_back(v);
      end

      foreach (vecs[i]) begin
         run_txn(vecs[i].x, vecs[i].z, vecs[i].hold, am, aa, as);
         check($sformatf("mag[%0d] x=%h", i, vecs[i].x), {16'd0, am}, {16'd0, vecs[i].mag});
         check($sformatf("ang[%0d] z=%h", i, vecs[i].z), {16'd0, aa}, {16'd0, vecs[i].ang});
         check($sformatf("sat[%0d]", i), {31'd0, as}, {31'd0, vecs[i].sat});
      end

      // Backpressure with a second request held valid throughout.
      in_valid = 1'b1; in_x = 16'h2000; in_z = 16'h0100;
      @(posedge clk); #1;
      in_x = 16'h1000; in_z = 16'h0200;
      seen = 0;
      for (int i = 1; i <= 40 && seen == 0; i++) begin
         @(posedge clk); #1;
         if (out_valid) seen = i;
      end
      check("bp_latency", seen, 16);
      check("bp_first_mag", {16'd0, out_mag}, 32'h26A4);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         check("bp_hold", {out_mag, out_ang}, {16'h26A4, 16'h0100});
         check("bp_hold_flags", {30'd0, out_valid, in_ready}, {30'd0, 1'b1, 1'b0});
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check("bp_release", {30'd0, out_valid, in_ready}, {30'd0, 1'b0, 1'b1});
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("bp_second_accepted", {31'd0, in_ready}, 32'd0);
      seen = 0;
      for (int i = 1; i <= 40 && seen == 0; i++) begin
         @(posedge clk); #1;
         if (out_valid) seen = i;
      end
      check("bp2_latency", seen, 16);
      check("bp2_mag", {out_mag, out_ang}, {16'h1352, 16'h0200});
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;

      // Reset pulse in the 8th multiply cycle aborts the operation.
      in_valid = 1'b1; in_x = 16'h7FFF; in_z = 16'h0300;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (7) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      check("mid_rst_in_ready", {31'd0, in_ready}, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      #1;
      check("after_rst_in_ready", {31'd0, in_ready}, 32'd1);
      seen = 0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         if (out_valid) seen++;
      end
      check("no_result_after_abort", seen, 0);
      run_txn(16'h2000, 16'h0000, 0, am, aa, as);
      check("after_rst_mag", {16'd0, am}, 32'h26A4);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
